// File: rtl/alu_pkg.sv
// Shared ALU control codes, RV32I opcodes and the decoded-issue payload type.
package alu_pkg;

    localparam logic [3:0] ALU_ADD   = 4'h0;
    localparam logic [3:0] ALU_SUB   = 4'h1;
    localparam logic [3:0] ALU_XOR   = 4'h2;
    localparam logic [3:0] ALU_OR    = 4'h3;
    localparam logic [3:0] ALU_AND   = 4'h4;
    localparam logic [3:0] ALU_SLL   = 4'h5;
    localparam logic [3:0] ALU_SRL   = 4'h6;
    localparam logic [3:0] ALU_BEQ   = 4'h7;
    localparam logic [3:0] ALU_BNE   = 4'h8;
    localparam logic [3:0] ALU_SLT   = 4'h9;
    localparam logic [3:0] ALU_SRA   = 4'hA;
    localparam logic [3:0] ALU_AUIPC = 4'hB;
    localparam logic [3:0] ALU_BLT   = 4'hC;
    localparam logic [3:0] ALU_BGE   = 4'hD;
    localparam logic [3:0] ALU_JAL   = 4'hE;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic [6:0] FUNCT7_ALT = 7'b0100000;

    typedef struct packed {
        logic [31:0] in1;
        logic [31:0] in2;
        logic [3:0]  ctrl;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_rd;
        logic        mem_wr;
        logic [31:0] store_data;
        logic        illegal;
    } issue_t;

endpackage

// File: rtl/alu_issue_stage_decode.sv
// Combinational RV32I decode: ALU control code, operand selection, side-effect flags.
module alu_ctrl_decode
    import alu_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output issue_t      dec
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        alt;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_j;
    logic [31:0] shamt;
    logic        bad;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign alt    = (funct7 == FUNCT7_ALT);
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_j  = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    assign shamt  = {27'd0, instr[24:20]};

    always_comb begin
        dec = '0;
        bad = 1'b0;
        unique case (opcode)
            OPC_OP: begin
                dec.in1       = rs1_data;
                dec.in2       = rs2_data;
                dec.reg_write = 1'b1;
                // The alternate funct7 is only meaningful for SUB and SRA.
                if (funct7 != 7'd0 && !(alt && (funct3 == 3'b000 || funct3 == 3'b101)))
                    bad = 1'b1;
                unique case (funct3)
                    3'b000:         dec.ctrl = alt ? ALU_SUB : ALU_ADD;
                    3'b001:         dec.ctrl = ALU_SLL;
                    3'b010, 3'b011: dec.ctrl = ALU_SLT;
                    3'b100:         dec.ctrl = ALU_XOR;
                    3'b101:         dec.ctrl = alt ? ALU_SRA : ALU_SRL;
                    3'b110:         dec.ctrl = ALU_OR;
                    default:        dec.ctrl = ALU_AND;
                endcase
            end
            OPC_OP_IMM: begin
                dec.in1       = rs1_data;
                dec.in2       = imm_i;
                dec.reg_write = 1'b1;
                unique case (funct3)
                    3'b000:         dec.ctrl = ALU_ADD;
                    3'b001: begin
                        dec.ctrl = ALU_SLL;
                        dec.in2  = shamt;
                    end
                    3'b010, 3'b011: dec.ctrl = ALU_SLT;
                    3'b100:         dec.ctrl = ALU_XOR;
                    3'b101: begin
                        dec.ctrl = alt ? ALU_SRA : ALU_SRL;
                        dec.in2  = shamt;
                    end
                    3'b110:         dec.ctrl = ALU_OR;
                    default:        dec.ctrl = ALU_AND;
                endcase
            end
            OPC_LUI: begin
                dec.in2       = {instr[31:12], 12'd0};
                dec.reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                dec.ctrl      = ALU_AUIPC;
                dec.in2       = {12'd0, instr[31:12]};
                dec.reg_write = 1'b1;
            end
            OPC_BRANCH: begin
                dec.in1 = rs1_data;
                dec.in2 = rs2_data;
                unique case (funct3)
                    3'b000:         dec.ctrl = ALU_BEQ;
                    3'b001:         dec.ctrl = ALU_BNE;
                    3'b100, 3'b110: dec.ctrl = ALU_BLT;
                    3'b101, 3'b111: dec.ctrl = ALU_BGE;
                    default:        bad      = 1'b1;
                endcase
            end
            OPC_JAL: begin
                dec.ctrl      = ALU_JAL;
                dec.in2       = imm_j;
                dec.reg_write = 1'b1;
            end
            OPC_LOAD: begin
                dec.in1       = rs1_data;
                dec.in2       = imm_i;
                dec.mem_rd    = 1'b1;
                dec.reg_write = 1'b1;
            end
            OPC_STORE: begin
                dec.in1        = rs1_data;
                dec.in2        = imm_s;
                dec.mem_wr     = 1'b1;
                dec.store_data = rs2_data;
            end
            default: bad = 1'b1;
        endcase

        if (bad) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
        dec.rd = dec.reg_write ? instr[11:7] : 5'd0;
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue register with valid/ready handshake and branch-flush squash.
// Optional performance counters are compiled in with ALU_ISSUE_PERF_EN.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int XLEN = 32
`ifdef ALU_ISSUE_PERF_EN
    ,
    parameter int PERF_W = 32
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_in1,
    output logic [XLEN-1:0] alu_in2,
    output logic [3:0]      alu_ctrl,
    output logic [XLEN-1:0] alu_pc,
    output logic [4:0]      rd,
    output logic            reg_write,
    output logic            mem_rd,
    output logic            mem_wr,
    output logic [XLEN-1:0] store_data,
    output logic            illegal,
    input  logic            branch_taken
`ifdef ALU_ISSUE_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_issued,
    output logic [PERF_W-1:0] perf_stall,
    output logic [PERF_W-1:0] perf_flush
`endif
);

    issue_t dec;
    issue_t q;
    logic   flush;

    alu_ctrl_decode u_decode (
        .instr    (instr),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .dec      (dec)
    );

    assign in_ready = !out_valid || out_ready;
    assign flush    = out_valid && out_ready && branch_taken;

    // Flush only kills the incoming valid; the payload still loads and is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            q         <= '0;
            alu_pc    <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid && !flush;
            q         <= dec;
            alu_pc    <= pc_in;
        end
    end

    assign alu_in1    = q.in1;
    assign alu_in2    = q.in2;
    assign alu_ctrl   = q.ctrl;
    assign rd         = q.rd;
    assign reg_write  = q.reg_write;
    assign mem_rd     = q.mem_rd;
    assign mem_wr     = q.mem_wr;
    assign store_data = q.store_data;
    assign illegal    = q.illegal;

`ifdef ALU_ISSUE_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_issued <= '0;
            perf_stall  <= '0;
            perf_flush  <= '0;
        end else begin
            if (in_ready && in_valid && !flush)
                perf_issued <= perf_issued + 1'b1;
            if (out_valid && !out_ready)
                perf_stall <= perf_stall + 1'b1;
            if (flush)
                perf_flush <= perf_flush + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed scenarios plus randomized traffic against a queue model.
module tb_alu_issue_stage;

    typedef struct packed {
        logic [31:0] in1;
        logic [31:0] in2;
        logic [3:0]  ctrl;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        rw;
        logic        mrd;
        logic        mwr;
        logic [31:0] sdata;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc_in;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_pc;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] store_data;
    logic        illegal;
    logic        branch_taken;

    int checks = 0;
    int errors = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    alu_issue_stage #(.XLEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .instr        (instr),
        .pc_in        (pc_in),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .alu_in1      (alu_in1),
        .alu_in2      (alu_in2),
        .alu_ctrl     (alu_ctrl),
        .alu_pc       (alu_pc),
        .rd           (rd),
        .reg_write    (reg_write),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .store_data   (store_data),
        .illegal      (illegal),
        .branch_taken (branch_taken)
    );

    // Reference decode, written from the instruction-set rules with plain arithmetic.
    function automatic exp_t ref_model(input logic [31:0] i, input logic [31:0] pc,
                                       input logic [31:0] r1, input logic [31:0] r2);
        exp_t e;
        int unsigned op, f3, f7;
        logic [3:0] op_tab [8];
        logic bad;
        op_tab = '{4'h0, 4'h5, 4'h9, 4'h9, 4'h2, 4'h6, 4'h3, 4'h4};
        op = i & 32'h7F;
        f3 = (i >> 12) & 7;
        f7 = i >> 25;
        e = '0;
        e.pc = pc;
        bad = 1'b0;
        if (op == 32'h33) begin
            e.in1 = r1; e.in2 = r2; e.rw = 1'b1; e.ctrl = op_tab[f3];
            if (f7 == 32) begin
                if (f3 == 0) e.ctrl = 4'h1;
                else if (f3 == 5) e.ctrl = 4'hA;
                else bad = 1'b1;
            end else if (f7 != 0) bad = 1'b1;
        end else if (op == 32'h13) begin
            e.in1 = r1; e.rw = 1'b1; e.ctrl = op_tab[f3];
            e.in2 = $unsigned($signed(i) >>> 20);
            if (f3 == 1 || f3 == 5) e.in2 = (i >> 20) & 31;
            if (f3 == 5 && f7 == 32) e.ctrl = 4'hA;
        end else if (op == 32'h37) begin
            e.in2 = i & 32'hFFFFF000; e.rw = 1'b1;
        end else if (op == 32'h17) begin
            e.ctrl = 4'hB; e.in2 = i >> 12; e.rw = 1'b1;
        end else if (op == 32'h63) begin
            e.in1 = r1; e.in2 = r2;
            case (f3)
                0: e.ctrl = 4'h7;
                1: e.ctrl = 4'h8;
                4, 6: e.ctrl = 4'hC;
                5, 7: e.ctrl = 4'hD;
                default: bad = 1'b1;
            endcase
        end else if (op == 32'h6F) begin
            e.ctrl = 4'hE; e.rw = 1'b1;
            e.in2 = (i[31] ? 32'hFFF00000 : 32'h0) | (i & 32'h000FF000)
                  | ((i >> 9) & 32'h800) | ((i >> 20) & 32'h7FE);
        end else if (op == 32'h03) begin
            e.in1 = r1; e.in2 = $unsigned($signed(i) >>> 20); e.mrd = 1'b1; e.rw = 1'b1;
        end else if (op == 32'h23) begin
            e.in1 = r1; e.mwr = 1'b1; e.sdata = r2;
            e.in2 = (($unsigned($signed(i) >>> 25)) << 5) | ((i >> 7) & 31);
        end else bad = 1'b1;
        if (bad) begin
            e = '0; e.pc = pc; e.ill = 1'b1;
        end
        e.rd = e.rw ? 5'((i >> 7) & 31) : 5'd0;
        return e;
    endfunction

    // One clock: advance the queue model with the currently driven inputs, then settle.
    task automatic tick();
        bit busy, fire, flush;
        busy  = (q.size() != 0);
        fire  = busy && out_ready;
        flush = fire && branch_taken;
        if (rst) q.delete();
        else begin
            if (fire) void'(q.pop_front());
            if ((!busy || out_ready) && in_valid && !flush)
                q.push_back(ref_model(instr, pc_in, rs1_data, rs2_data));
        end
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int unsigned kind, f3, f7;
        w = $urandom;
        f3 = (w >> 12) & 7;
        kind = $urandom_range(0, 11);
        f7 = 0;
        case (kind)
            0, 1: begin
                w[6:0] = 7'h33;
                if ((f3 == 0 || f3 == 5) && $urandom_range(0, 1) == 1) f7 = 32;
                if ($urandom_range(0, 7) == 0) f7 = 1 + 2 * $urandom_range(0, 50);
                w[31:25] = 7'(f7);
            end
            2, 3: begin
                w[6:0] = 7'h13;
                if (f3 == 1) w[31:25] = 7'd0;
                if (f3 == 5) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            end
            4: w[6:0] = 7'h37;
            5: w[6:0] = 7'h17;
            6: w[6:0] = 7'h63;
            7: w[6:0] = 7'h6F;
            8: w[6:0] = 7'h03;
            9: w[6:0] = 7'h23;
            10: w[6:0] = 7'h0B;
            default: w[6:0] = ($urandom_range(0, 1) == 1) ? 7'h67 : 7'h73;
        endcase
        return w;
    endfunction

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] r1,
                         input logic [31:0] r2, input logic ordy, input logic bt);
        in_valid = v; instr = ins; rs1_data = r1; rs2_data = r2;
        out_ready = ordy; branch_taken = bt; pc_in = $urandom;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 32'h402081B3, 32'd10, 32'd3, 1'b1, 1'b0);
        tick(); tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", out_valid); end
        checks++;
        if (alu_ctrl !== 4'h0) begin errors++; $display("FAIL reset_ctrl got %0h want 0", alu_ctrl); end
        checks++;
        if ({alu_in1, alu_in2, alu_pc, rd, reg_write, mem_rd, mem_wr, store_data, illegal} !== '0) begin
            errors++;
            $display("FAIL reset_payload got %h/%h/%h rd=%0d want all zero", alu_in1, alu_in2, alu_pc, rd);
        end
        rst = 1'b0;
    endtask

    task automatic test_sub();
        logic [31:0] pc;
        pc = pc_in;
        tick();
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL sub_valid got %0b want 1", out_valid); end
        checks++;
        if ({alu_ctrl, alu_in1, alu_in2, rd, reg_write, alu_pc} !== {4'h1, 32'd10, 32'd3, 5'd3, 1'b1, pc}) begin
            errors++;
            $display("FAIL sub_payload got ctrl=%0h in1=%0d in2=%0d rd=%0d rw=%0b pc=%h want 1/10/3/3/1/%h",
                     alu_ctrl, alu_in1, alu_in2, rd, reg_write, alu_pc, pc);
        end
    endtask

    task automatic test_imm();
        drive(1'b1, 32'hFFF00293, 32'd77, 32'd0, 1'b1, 1'b0);
        tick();
        checks++;
        if ({alu_ctrl, alu_in2, rd} !== {4'h0, 32'hFFFFFFFF, 5'd5}) begin
            errors++;
            $display("FAIL addi got ctrl=%0h in2=%h rd=%0d want 0/ffffffff/5", alu_ctrl, alu_in2, rd);
        end
        drive(1'b1, 32'h12345097, 32'd5, 32'd6, 1'b1, 1'b0);
        tick();
        checks++;
        if ({alu_ctrl, alu_in1, alu_in2, rd} !== {4'hB, 32'd0, 32'h00012345, 5'd1}) begin
            errors++;
            $display("FAIL auipc got ctrl=%0h in1=%h in2=%h rd=%0d want b/0/00012345/1",
                     alu_ctrl, alu_in1, alu_in2, rd);
        end
        drive(1'b1, 32'h0000000B, 32'd5, 32'd6, 1'b1, 1'b0);
        tick();
        checks++;
        if ({out_valid, illegal, reg_write, mem_wr, mem_rd} !== 5'b11000) begin
            errors++;
            $display("FAIL illegal got v=%0b ill=%0b rw=%0b mw=%0b mr=%0b want 1/1/0/0/0",
                     out_valid, illegal, reg_write, mem_wr, mem_rd);
        end
    endtask

    task automatic test_stall();
        drive(1'b1, 32'h00208233, 32'd1, 32'd2, 1'b1, 1'b0);
        tick();
        drive(1'b1, 32'h0020C333, 32'd1, 32'd2, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if ({in_ready, out_valid, alu_ctrl, rd} !== {1'b0, 1'b1, 4'h0, 5'd4}) begin
                errors++;
                $display("FAIL stall_hold cyc=%0d got rdy=%0b v=%0b ctrl=%0h rd=%0d want 0/1/0/4",
                         k, in_ready, out_valid, alu_ctrl, rd);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release got rdy=%0b want 1", in_ready); end
        tick();
        checks++;
        if ({out_valid, alu_ctrl, rd} !== {1'b1, 4'h2, 5'd6}) begin
            errors++;
            $display("FAIL stall_next got v=%0b ctrl=%0h rd=%0d want 1/2/6", out_valid, alu_ctrl, rd);
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_nodup got v=%0b want 0", out_valid); end
    endtask

    task automatic test_flush();
        drive(1'b1, 32'h00208063, 32'd4, 32'd4, 1'b1, 1'b0);
        tick();
        checks++;
        if ({out_valid, alu_ctrl, reg_write, rd} !== {1'b1, 4'h7, 1'b0, 5'd0}) begin
            errors++;
            $display("FAIL beq_issue got v=%0b ctrl=%0h rw=%0b rd=%0d want 1/7/0/0", out_valid, alu_ctrl, reg_write, rd);
        end
        drive(1'b1, 32'h00208233, 32'd1, 32'd2, 1'b1, 1'b1);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %0b want 1", in_ready); end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_squash got v=%0b want 0", out_valid); end
        drive(1'b0, 32'h0, 32'd0, 32'd0, 1'b1, 1'b0);
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_never got v=%0b want 0", out_valid); end
    endtask

    task automatic test_random();
        exp_t act;
        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom,
                  $urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0);
            #1;
            checks++;
            if (out_valid !== (q.size() != 0) || in_ready !== (q.size() == 0 || out_ready)) begin
                errors++;
                $display("FAIL rand_hs n=%0d got v=%0b rdy=%0b want v=%0b rdy=%0b", n, out_valid, in_ready,
                         q.size() != 0, q.size() == 0 || out_ready);
            end
            if (q.size() != 0) begin
                act = '{alu_in1, alu_in2, alu_ctrl, alu_pc, rd, reg_write, mem_rd, mem_wr, store_data, illegal};
                checks++;
                if (act !== q[0]) begin
                    errors++;
                    $display("FAIL rand_payload n=%0d got %h want %h", n, act, q[0]);
                end
            end
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 32'h0, 32'd0, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        test_reset();
        test_sub();
        test_imm();
        test_stall();
        test_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
ID/EX issue stage and the producer side of the ALU operand/control interface. It decodes an RV32I instruction into the 4-bit ALU control code, selects and extends operands, and registers them with control into the ID/EX pipeline register. Its outputs drive the ALU's in1/in2/ctrl/PC inputs combinationally in EX. It uses the ALU's branch_taken result to squash the wrong-path instruction.

Parameters:
XLEN, 32, datapath width; only 32 is supported.
PERF_W, 32, width of each performance counter when the optional feature is compiled in.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  decode slot holds an instruction
in_ready  output  1  stage accepts the input this cycle
instr  input  32  instruction word
pc_in  input  32  word-index PC of the instruction
rs1_data  input  32  register-file read data for rs1
rs2_data  input  32  register-file read data for rs2
out_valid  output  1  EX slot holds a valid instruction
out_ready  input  1  EX consumes the slot this cycle
alu_in1  output  32  ALU operand 1
alu_in2  output  32  ALU operand 2
alu_ctrl  output  4  ALU control code
alu_pc  output  32  PC forwarded to the ALU
rd  output  5  destination register
reg_write  output  1  writeback enable
mem_rd  output  1  load
mem_wr  output  1  store
store_data  output  32  rs2 value for stores
illegal  output  1  unsupported opcode or funct
branch_taken  input  1  ALU result for the current EX slot

Behaviour:
- Reset (synchronous, rst high at the clock edge): all registered outputs are 0. out_valid is 0, and alu_ctrl is 0 (ADD).
- ALU control codes:
  - 0 ADD, 1 SUB, 2 XOR, 3 OR, 4 AND, 5 SLL, 6 SRL, 7 BEQ.
  - 8 BNE, 9 SLT, A SRA, B AUIPC, C BLT, D BGE, E JAL.
- Handshake: in_ready = !out_valid || out_ready. The register loads only when in_ready is high.
- Latency: one cycle from acceptance to out_valid.
- No combinational path from in_valid to in_ready.
- flush = out_valid && out_ready && branch_taken. On flush, the instruction accepted in the same cycle is dropped: out_valid is 0 next cycle and the payload is don't-care.
- Flush has priority over load. in_ready stays high during flush, so upstream sees the instruction as consumed.
- Load rule when in_ready is high and there is no flush: out_valid is set to in_valid.
- Hold rule when in_ready is low: all outputs hold their values.
- Decode, by opcode:
  - OP (0110011), in1=rs1, in2=rs2:
    - funct3 000: ADD, or SUB when funct7=0100000.
    - 100 XOR, 110 OR, 111 AND, 001 SLL.
    - 101: SRL, or SRA when funct7=0100000.
    - 010 and 011: SLT (code 9).
    - Any other funct7 is illegal.
  - OP-IMM (0010011): in2 is the sign-extended I-imm.
    - Shifts use shamt zero-extended as in2.
    - SRAI is selected when funct7=0100000.
  - LUI: ADD with in1=0 and in2={instr[31:12],12'b0}.
  - AUIPC: code B with in1=0 and in2={12'b0,instr[31:12]}. The ALU itself scales the PC and shifts in2.
  - BRANCH: funct3 000→7, 001→8, 100 and 110→C, 101 and 111→D. in1=rs1, in2=rs2, reg_write=0. funct3 010 and 011 are illegal.
  - JAL: code E, reg_write=1.
  - LOAD: ADD of rs1 and I-imm, mem_rd=1, reg_write=1.
  - STORE: ADD of rs1 and S-imm, mem_wr=1, reg_write=0, store_data=rs2.
  - Other opcodes: illegal=1 with ctrl ADD, operands 0, and reg_write, mem_rd, mem_wr all 0.
- rd is forced to 0 when reg_write is 0. A write to x0 is still issued as decoded; the register file ignores it.
- alu_pc = pc_in, registered.

Optional Feature:
ALU_ISSUE_PERF_EN:
- When defined, adds three PERF_W output counters, each reset to 0 and wrapping on overflow:
  - perf_issued: increments on each load with in_valid high and no flush.
  - perf_stall: increments each cycle out_valid is high and out_ready is low.
  - perf_flush: increments on each flush.
- When undefined, these ports and the counter logic do not exist.

Decomposition:
- Package alu_pkg holds:
  - the 4-bit ALU control code localparams (ALU_ADD..ALU_JAL);
  - RV32I opcode constants;
  - the funct7 constant 0100000.
  The existing ALU adopts the same package.
- Sub-module alu_ctrl_decode is a purely combinational mapping from instr, rs1 and rs2 to the operands, ctrl, flags and illegal. alu_issue_stage adds the register, handshake and flush around it.

Test Plan:
- Reset with rst high for 2 cycles, in_valid=1 → out_valid=0, alu_ctrl=0, all outputs 0. The first instruction issues one cycle after rst falls.
- SUB x3,x1,x2 (0x402081B3) with rs1=10, rs2=3, in_valid=1, out_ready=1 → next cycle alu_ctrl=1, in1=10, in2=3, rd=3, reg_write=1.
- ADDI x5,x0,-1 (0xFFF00293) → alu_in2=0xFFFFFFFF and ctrl=0. AUIPC x1,0x12345 → ctrl=B, in2=0x00012345.
- Hold out_ready=0 for 3 cycles with in_valid=1 → in_ready=0, outputs stable. Then out_ready=1 → next instruction loads in one cycle, with no loss or duplication.
- BEQ in EX with branch_taken=1 while an ADD is presented with in_valid=1 → in_ready=1, out_valid=0 next cycle, and the ADD is never issued.
- Opcode 0x0000000B → illegal=1, reg_write=0, mem_wr=0.
